// File: rtl/anc_pkg.sv
// Shared types for the ANC sample sequencer: FSM state encoding and the
// registered per-cycle pulse bundle driven towards the datapath stages.
package anc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        W_DC  = 3'd1,
        W_LP  = 3'd2,
        W_ERR = 3'd3,
        W_LMS = 3'd4,
        W_FIR = 3'd5
    } seq_state_t;

    localparam int ANC_TIMEOUT_DEFAULT = 2048;

    typedef struct packed {
        logic dc;
        logic lp;
        logic err;
        logic lms;
        logic fir;
        logic out_valid;
        logic bypass;
    } seq_pulse_t;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog: counts cycles spent waiting on one stage and flags
// expiry once the count reaches TIMEOUT_CYCLES-1.
module stage_watchdog #(
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int TIMEOUT_W      = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end

    assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/anc_pipeline_sequencer.sv
// Per-sample scheduler for the ANC datapath: issues each stage's start pulse in
// order, with a per-stage watchdog, dropped-strobe counting and bypass/freeze modes.
module anc_pipeline_sequencer
    import anc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = ANC_TIMEOUT_DEFAULT,
    parameter int TIMEOUT_W      = 12,
    parameter int OVR_W          = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             sample_ready_in,
    input  logic             nc_on_in,
    input  logic             adapt_en_in,
    input  logic             status_clr_in,
    output logic             dc_ready_out,
    input  logic             dc_done_in,
    output logic             lp_ready_out,
    input  logic             lp_done_in,
    output logic             err_ready_out,
    input  logic             err_done_in,
    output logic             lms_ready_out,
    input  logic             lms_done_in,
    output logic             fir_ready_out,
    input  logic             fir_done_in,
    output logic             out_valid_out,
    output logic             bypass_out,
    output logic             busy_out,
    output logic             timeout_out,
    output logic [OVR_W-1:0] overrun_count_out,
    output logic [2:0]       state_out
);

    logic [1:0]       rst_sync;
    logic             rst;
    seq_state_t       state, state_nxt;
    seq_pulse_t       pulse_q, pulse_nxt;
    logic             stage_done;
    logic             wd_expired;
    logic             timeout_set;
    logic             timeout_q;
    logic             ovr_inc;
    logic [OVR_W-1:0] ovr_cnt;

    // Assert immediately, release on the clock so no flop leaves reset mid-edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            rst_sync <= 2'b11;
        else
            rst_sync <= {rst_sync[0], 1'b0};
    end

    assign rst = rst_sync[1];

    // The done that matters is the one the current state is waiting on; others are ignored.
    always_comb begin
        stage_done = 1'b0;
        case (state)
            W_DC:    stage_done = dc_done_in;
            W_LP:    stage_done = lp_done_in;
            W_ERR:   stage_done = err_done_in;
            W_LMS:   stage_done = lms_done_in;
            W_FIR:   stage_done = fir_done_in;
            default: stage_done = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        pulse_nxt   = '0;
        timeout_set = 1'b0;
        case (state)
            IDLE: if (sample_ready_in) begin
                pulse_nxt.dc = 1'b1;
                state_nxt    = W_DC;
            end
            W_DC: if (stage_done) begin
                pulse_nxt.lp = 1'b1;
                state_nxt    = W_LP;
            end
            W_LP: if (stage_done) begin
                if (!nc_on_in) begin
                    pulse_nxt.out_valid = 1'b1;
                    pulse_nxt.bypass    = 1'b1;
                    state_nxt           = IDLE;
                end else begin
                    pulse_nxt.err = 1'b1;
                    state_nxt     = W_ERR;
                end
            end
            W_ERR: if (stage_done) begin
                if (adapt_en_in) begin
                    pulse_nxt.lms = 1'b1;
                    state_nxt     = W_LMS;
                end else begin
                    pulse_nxt.fir = 1'b1;
                    state_nxt     = W_FIR;
                end
            end
            W_LMS: if (stage_done) begin
                pulse_nxt.fir = 1'b1;
                state_nxt     = W_FIR;
            end
            W_FIR: if (stage_done) begin
                pulse_nxt.out_valid = 1'b1;
                state_nxt           = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A done landing on the expiry cycle still counts as on time.
        if (state != IDLE && !stage_done && wd_expired) begin
            state_nxt   = IDLE;
            timeout_set = 1'b1;
        end
    end

    stage_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_watchdog (
        .clk     (clk_in),
        .rst     (rst),
        .clr     (state_nxt != state),
        .en      (state != IDLE),
        .expired (wd_expired)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pulse_q <= '0;
        end else begin
            state   <= state_nxt;
            pulse_q <= pulse_nxt;
        end
    end

    assign ovr_inc = sample_ready_in && (state != IDLE);

    // Set/increment events take priority over a coincident status clear.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
            ovr_cnt   <= '0;
        end else begin
            if (timeout_set)
                timeout_q <= 1'b1;
            else if (status_clr_in)
                timeout_q <= 1'b0;

            if (ovr_inc)
                ovr_cnt <= status_clr_in ? OVR_W'(1) : ((&ovr_cnt) ? ovr_cnt : ovr_cnt + 1'b1);
            else if (status_clr_in)
                ovr_cnt <= '0;
        end
    end

    assign dc_ready_out      = pulse_q.dc;
    assign lp_ready_out      = pulse_q.lp;
    assign err_ready_out     = pulse_q.err;
    assign lms_ready_out     = pulse_q.lms;
    assign fir_ready_out     = pulse_q.fir;
    assign out_valid_out     = pulse_q.out_valid;
    assign bypass_out        = pulse_q.bypass;
    assign busy_out          = (state != IDLE);
    assign timeout_out       = timeout_q;
    assign overrun_count_out = ovr_cnt;
    assign state_out         = state;

endmodule
